// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: core vs. program loader, one access per cycle.
// Starvation counter bounds loader wait; EXCL mode hands the memory to the loader.

module data_mem_arbiter_rport #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = cap;
    rdata_d  = cap ? rdata_in : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

module data_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_wr,
  input  logic [2:0]        core_type,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              ldr_req,
  input  logic              ldr_wr,
  input  logic [2:0]        ldr_type,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_excl,
  output logic              core_gnt,
  output logic              ldr_gnt,
  output logic              core_rvalid,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              stall_core,
  output logic              excl_active,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic [2:0]        mem_type,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NUM_PORTS = 2;
  localparam int CORE      = 0;
  localparam int LDR       = 1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef struct packed {
    logic              wr;
    logic [2:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  typedef enum logic {SHARED = 1'b0, EXCL = 1'b1} state_e;

  logic [NUM_PORTS-1:0]             req, gnt, cap, rvalid;
  acc_t [NUM_PORTS-1:0]             acc;
  acc_t                             mem_sel;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;
  state_e                           state_q, state_d;
  logic [3:0]                       starve_cnt_q, starve_cnt_d;

  assign req[CORE] = core_req;
  assign req[LDR]  = ldr_req;
  assign acc[CORE] = {core_wr, core_type, core_addr, core_wdata};
  assign acc[LDR]  = {ldr_wr, ldr_type, ldr_addr, ldr_wdata};

  always_comb begin
    state_d      = ldr_excl ? EXCL : SHARED;
    gnt          = '0;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      SHARED: begin
        if (req[CORE] && req[LDR]) begin
          // Counter saturates at the limit, so >= is the forced-loader condition
          if (starve_cnt_q >= STARVE_LIM) begin
            gnt[LDR] = 1'b1;
          end else begin
            gnt[CORE]    = 1'b1;
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (req[CORE]) begin
          gnt[CORE] = 1'b1;
        end else if (req[LDR]) begin
          gnt[LDR] = 1'b1;
        end
        if (!req[LDR] || gnt[LDR]) starve_cnt_d = '0;
      end
      EXCL: begin
        gnt[LDR]     = req[LDR];
        starve_cnt_d = '0;
      end
      default: starve_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SHARED;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Idle cycles drive an all-zero access so the memory never sees a stray write
  always_comb begin
    mem_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (gnt[p]) mem_sel = acc[p];
  end

  assign mem_addr  = mem_sel.addr;
  assign mem_wdata = mem_sel.wdata;
  assign mem_wr    = mem_sel.wr;
  assign mem_type  = mem_sel.typ;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign cap[p] = gnt[p] & ~acc[p].wr;
    data_mem_arbiter_rport #(.DATA_W(DATA_W)) u_rport (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap      (cap[p]),
      .rdata_in (mem_rdata),
      .rvalid   (rvalid[p]),
      .rdata    (rdata[p])
    );
  end

  assign core_gnt    = gnt[CORE];
  assign ldr_gnt     = gnt[LDR];
  assign stall_core  = core_req & ~gnt[CORE];
  assign excl_active = (state_q == EXCL);
  assign core_rvalid = rvalid[CORE];
  assign ldr_rvalid  = rvalid[LDR];
  assign core_rdata  = rdata[CORE];
  assign ldr_rdata   = rdata[LDR];
endmodule
